duck_palette_ctrl: RTL

DUCK_PALETTE_CTRL -- requirements
Module: duck_palette_ctrl

---
 rtl/duck_palette_ctrl_if.sv | 28 ++
 rtl/duck_palette_ctrl.sv | 111 +++++++++++
 2 files changed

// File: rtl/duck_palette_ctrl_if.sv
// Palette controller bus: shadow write port, commit/flash control and pixel lookup path.
interface duck_palette_ctrl_if;
    logic        vsync_pulse;
    logic        wr_valid;
    logic        wr_ready;
    logic [3:0]  wr_index;
    logic [11:0] wr_rgb;
    logic        commit;
    logic        commit_pending;
    logic        flash_req;
    logic        flashing;
    logic        pix_valid;
    logic [3:0]  pix_index;
    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;
    logic        rgb_valid;

    modport master (
        output vsync_pulse, wr_valid, wr_index, wr_rgb, commit, flash_req, pix_valid, pix_index,
        input  wr_ready, commit_pending, flashing, red, green, blue, rgb_valid
    );

    modport slave (
        input  vsync_pulse, wr_valid, wr_index, wr_rgb, commit, flash_req, pix_valid, pix_index,
        output wr_ready, commit_pending, flashing, red, green, blue, rgb_valid
    );
endinterface

// File: rtl/duck_palette_ctrl.sv
// Double-buffered 16-entry palette with vsync-timed shadow-to-active copy and hit flash.
//   state | meaning
//   IDLE  | no commit outstanding, shadow writes accepted
//   ARMED | commit pending, waiting for the next vsync_pulse
//   COPY  | copying shadow[k] -> active[k], one entry per cycle
module duck_palette_ctrl #(
    parameter int unsigned FLASH_FRAMES    = 8,
    parameter int unsigned TRANSPARENT_IDX = 1
) (
    input  logic               Clk,
    input  logic               Reset_n,
    duck_palette_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ARMED, COPY} state_t;

    localparam logic [3:0] FLASH_LOAD = 4'(FLASH_FRAMES);
    localparam logic [3:0] TRANSP     = 4'(TRANSPARENT_IDX);

    state_t      state, state_nxt;
    logic [3:0]  copy_idx;
    logic        commit_lat;
    logic [3:0]  flash_cnt;
    logic [11:0] shadow [16];
    logic [11:0] active [16];
    logic [11:0] colour;
    logic        wr_fire;
    logic        copy_last;

    function automatic logic [11:0] reset_colour(input int k);
        case (k)
            0:       reset_colour = 12'h00A;
            2:       reset_colour = 12'hFFF;
            3:       reset_colour = 12'hB0B;
            4:       reset_colour = 12'hF76;
            default: reset_colour = 12'hAEA;
        endcase
    endfunction

    assign bus.wr_ready       = (state != COPY);
    assign bus.commit_pending = (state != IDLE);
    assign bus.flashing       = (flash_cnt != 4'd0);
    assign wr_fire            = bus.wr_valid && bus.wr_ready;
    assign copy_last          = (copy_idx == 4'hF);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.commit) state_nxt = ARMED;
            ARMED:   if (bus.vsync_pulse) state_nxt = COPY;
            COPY:    if (copy_last) state_nxt = (commit_lat || bus.commit) ? ARMED : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= IDLE;
            copy_idx   <= 4'd0;
            commit_lat <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == COPY) begin
                copy_idx   <= copy_idx + 4'd1;
                commit_lat <= copy_last ? 1'b0 : (commit_lat || bus.commit);
            end else begin
                copy_idx   <= 4'd0;
                commit_lat <= 1'b0;
            end
        end
    end

    // Both banks reload on reset so an interrupted copy leaves nothing behind.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int k = 0; k < 16; k++) begin
                shadow[k] <= reset_colour(k);
                active[k] <= reset_colour(k);
            end
        end else begin
            if (wr_fire) shadow[bus.wr_index] <= bus.wr_rgb;
            if (state == COPY) active[copy_idx] <= shadow[copy_idx];
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            flash_cnt <= 4'd0;
        end else if (bus.flash_req) begin
            flash_cnt <= FLASH_LOAD;
        end else if (bus.vsync_pulse && flash_cnt != 4'd0) begin
            flash_cnt <= flash_cnt - 4'd1;
        end
    end

    always_comb begin
        colour = active[bus.pix_index];
        if (flash_cnt[0] && bus.pix_index != TRANSP) colour = 12'hFFF;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            bus.red       <= 4'd0;
            bus.green     <= 4'd0;
            bus.blue      <= 4'd0;
            bus.rgb_valid <= 1'b0;
        end else begin
            bus.rgb_valid <= bus.pix_valid;
            if (bus.pix_valid) {bus.red, bus.green, bus.blue} <= colour;
        end
    end
endmodule
